// File: rtl/mem_access_unit.sv
// Load/store front-end between the EX/MEM boundary and the byte-addressed data RAM.
// Validates each request, drives the RAM ports and returns extended load data.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a request; stores and rejected requests finish here
// LOAD_WAIT | RAM read word arrives this cycle; extract and register result
module mem_access_unit #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_is_store,
   input  logic [2:0]            i_funct3,
   input  logic [31:0]           i_addr,
   input  logic [31:0]           i_wdata,
   output logic [ADDR_WIDTH-1:0] o_mem_waddr,
   output logic [ADDR_WIDTH-1:0] o_mem_raddr,
   output logic [31:0]           o_mem_din,
   output logic [1:0]            o_mem_wsize,
   output logic                  o_mem_wen,
   output logic                  o_mem_ren,
   input  logic [31:0]           i_mem_dout,
   output logic                  o_rsp_valid,
   output logic                  o_rsp_is_load,
   output logic [31:0]           o_rdata,
   output logic                  o_err
);

   typedef enum logic {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        misaligned;
   logic        out_of_range;
   logic        bad_funct3;
   logic        req_err;
   logic [1:0]  store_size;
   logic [2:0]  load_funct3;
   logic [31:0] load_word;

   assign o_mem_waddr = i_addr[ADDR_WIDTH-1:0];
   assign o_mem_raddr = i_addr[ADDR_WIDTH-1:0];
   assign o_mem_din   = i_wdata;

   always_comb begin
      misaligned = 1'b0;
      case (i_funct3[1:0])
         2'b01:   misaligned = i_addr[0];
         2'b10:   misaligned = |i_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign out_of_range = |i_addr[31:ADDR_WIDTH];

   always_comb begin
      bad_funct3 = 1'b1;
      if (i_req_is_store) begin
         bad_funct3 = (i_funct3 > 3'b010);
      end else begin
         case (i_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_funct3 = 1'b0;
            default:                                bad_funct3 = 1'b1;
         endcase
      end
   end

   assign req_err = misaligned | out_of_range | bad_funct3;

   always_comb begin
      store_size = 2'b00;
      case (i_funct3[1:0])
         2'b00:   store_size = 2'b01;
         2'b01:   store_size = 2'b10;
         2'b10:   store_size = 2'b11;
         default: store_size = 2'b00;
      endcase
   end

   // Reset wins over a pending request: nothing is accepted while i_rst is high.
   always_comb begin
      state_nxt   = state;
      o_req_ready = 1'b0;
      accept      = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_ren   = 1'b0;
      o_mem_wsize = 2'b00;
      case (state)
         IDLE: begin
            o_req_ready = ~i_rst;
            accept      = i_req_valid & ~i_rst;
            if (accept && !req_err) begin
               if (i_req_is_store) begin
                  o_mem_wen   = 1'b1;
                  o_mem_wsize = store_size;
               end else begin
                  o_mem_ren = 1'b1;
                  state_nxt = LOAD_WAIT;
               end
            end
         end
         LOAD_WAIT: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_word = i_mem_dout;
      case (load_funct3)
         3'b000:  load_word = {{24{i_mem_dout[7]}}, i_mem_dout[7:0]};
         3'b001:  load_word = {{16{i_mem_dout[15]}}, i_mem_dout[15:0]};
         3'b100:  load_word = {24'd0, i_mem_dout[7:0]};
         3'b101:  load_word = {16'd0, i_mem_dout[15:0]};
         default: load_word = i_mem_dout;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state         <= IDLE;
         load_funct3   <= 3'b000;
         o_rsp_valid   <= 1'b0;
         o_rsp_is_load <= 1'b0;
         o_err         <= 1'b0;
         o_rdata       <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept && !i_req_is_store) begin
            load_funct3 <= i_funct3;
         end
         // Stores and rejected requests answer straight from IDLE; o_rdata is kept on errors.
         if (accept && (i_req_is_store || req_err)) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_is_load <= ~i_req_is_store;
            o_err         <= req_err;
         end else if (state == LOAD_WAIT) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_is_load <= 1'b1;
            o_err         <= 1'b0;
            o_rdata       <= load_word;
         end else begin
            o_rsp_valid   <= 1'b0;
            o_rsp_is_load <= 1'b0;
            o_err         <= 1'b0;
         end
      end
   end

endmodule
